mmio_dbus: RTL



---
 rtl/mmio_pkg.sv | 47 ++++
 rtl/tx_fifo.sv | 65 ++++++
 rtl/mmio_dbus.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared definitions for the data-side MMIO bus: address map
//                constants, STATUS bit positions, the region enum and the
//                address decoder helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_pkg;

    // Memory-mapped register addresses (byte addresses, word aligned)
    localparam logic [31:0] MMIO_TXDATA  = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_STATUS  = 32'hFFFF_0004;
    localparam logic [31:0] MMIO_CYCLES  = 32'hFFFF_0008;
    // Upper half-word that selects the RAM window
    localparam logic [15:0] MMIO_RAM_TAG = 16'h0000;

    // STATUS register bit indices
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    typedef enum logic [2:0] {
        REG_RAM  = 3'd0,
        REG_TX   = 3'd1,
        REG_STAT = 3'd2,
        REG_CYC  = 3'd3,
        REG_NONE = 3'd4
    } region_e;

    // Takes only the word address: the byte offset never affects decoding.
    function automatic region_e mmio_decode(input logic [31:2] waddr);
        region_e r;
        r = REG_NONE;
        if (waddr[31:16] == MMIO_RAM_TAG)
            r = REG_RAM;
        else if (waddr == MMIO_TXDATA[31:2])
            r = REG_TX;
        else if (waddr == MMIO_STATUS[31:2])
            r = REG_STAT;
        else if (waddr == MMIO_CYCLES[31:2])
            r = REG_CYC;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : 8-bit first-word-fall-through FIFO, depth 2**AW.
//                Pointers carry one extra wrap bit; full/empty come from
//                comparing them. dout is forced to 0 while empty so the
//                (unreset) storage never leaks onto the output.
//  Ports       : clk, reset (async, active-high), push, pop, din[7:0],
//                dout[7:0], empty, full, count[AW:0]
//  Revision    : 1.0  initial release
// ============================================================================
module tx_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int        DEPTH = 2 ** AW;
    localparam logic [AW:0] c_one = 1;

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    // Pop only real data; push when space exists or the head leaves this cycle.
    // On full+pop+push the write lands in the slot being read out, which is
    // safe because the read is combinational from the pre-edge contents.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + c_one;
            if (w_pop)
                r_rptr <= r_rptr + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign count = r_wptr - r_rptr;
    assign dout  = empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/mmio_dbus.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_dbus
//  Description : Data-side bus for a single-cycle core. Decodes the cpu
//                address into word RAM, a TX byte FIFO, a STATUS register
//                and an optional free-running cycle counter; loads are
//                combinational, stores take effect on the clock edge.
//  Ports       : clk, reset (async, active-high), memwrite, addr[n-1:0],
//                writedata[n-1:0], readdata[n-1:0] (comb), tx_data[7:0],
//                tx_valid, tx_ready, tx_overflow (sticky)
//  Options     : MMIO_CYCLE_COUNTER_EN - define to build the CYCLES counter;
//                otherwise CYCLES reads 0 and ignores writes.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_dbus
    import mmio_pkg::*;
#(
    parameter int n       = 32,
    parameter int RAM_AW  = 8,
    parameter int FIFO_AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [n-1:0]  addr,
    input  logic [n-1:0]  writedata,
    output logic [n-1:0]  readdata,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_overflow
);

    localparam logic [FIFO_AW:0] c_depth = 2 ** FIFO_AW;

    region_e            w_region;
    logic               w_ram_we;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_stat_we;
    logic               w_empty;
    logic               w_full;
    logic [FIFO_AW:0]   w_count;
    logic [n-1:0]       w_cycles;
    logic [n-1:0]       w_status;
    logic               r_ovf;
    logic [n-1:0]       r_ram [2 ** RAM_AW];

    // Byte offset and the aliased in-window RAM bits play no part in decode.
    logic               w_unused;
    assign w_unused = ^{addr[1:0], addr[15:RAM_AW+2]};

    assign w_region   = mmio_decode(addr[31:2]);
    assign w_ram_we   = memwrite & (w_region == REG_RAM);
    assign w_push_req = memwrite & (w_region == REG_TX);
    assign w_stat_we  = memwrite & (w_region == REG_STAT);

    assign tx_valid = ~w_empty;
    assign w_pop    = tx_valid & tx_ready;
    // A full FIFO still accepts a byte when the sink drains one this cycle.
    assign w_push   = w_push_req & ((w_count != c_depth) | w_pop);
    assign w_drop   = w_push_req & ~w_push;

    tx_fifo #(
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (writedata[7:0]),
        .dout  (tx_data),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // Sticky overflow; a drop outranks a clear landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (w_stat_we)
            r_ovf <= 1'b0;
    end
    assign tx_overflow = r_ovf;

    // Word RAM: not reset, write on the edge, so a same-cycle load sees old data.
    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[addr[RAM_AW+1:2]] <= writedata;
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic         w_cyc_we;
    logic [n-1:0] r_cycles;
    assign w_cyc_we = memwrite & (w_region == REG_CYC);

    // A software load takes precedence over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cycles <= '0;
        else if (w_cyc_we)
            r_cycles <= writedata;
        else
            r_cycles <= r_cycles + 1'b1;
    end
    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    always_comb begin
        w_status           = '0;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL]  = w_full;
        w_status[ST_OVF]   = r_ovf;
    end

    always_comb begin
        readdata = '0;
        case (w_region)
            REG_RAM:  readdata = r_ram[addr[RAM_AW+1:2]];
            REG_TX:   readdata = {{(n-8){1'b0}}, tx_data};
            REG_STAT: readdata = w_status;
            REG_CYC:  readdata = w_cycles;
            default:  readdata = '0;
        endcase
    end

endmodule
`default_nettype wire
